// File: rtl/inst_loader_pkg.sv
// Shared widths, memory size and loader state encoding for the boot-time
// instruction loader.
package inst_loader_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int INST_MEM_NUM = 4096;

  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_LEN  = 3'd1,
    LD_DATA = 3'd2,
    LD_DONE = 3'd3,
    LD_ERR  = 3'd4
  } ld_state_e;

  // The packer delivers {b0,b1,b2,b3}; the count field is little-endian.
  function automatic logic [31:0] le_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Collects four stream bytes into one word, first byte in the top lane.
// word_o is valid only in the cycle the fourth byte is presented.
module inst_loader_byte_packer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (clear_i) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_i};
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes words into the
// instruction RAM and holds the CPU in reset until the image is complete.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = INST_MEM_NUM,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_rst
);

  localparam logic [31:0] MEM_LIMIT = MEM_WORDS;
  localparam logic [31:0] TO_LAST   = TIMEOUT - 1;

  ld_state_e             state_q, state_d;
  logic [31:0]           idx_q, idx_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           idle_q, idle_d;
  logic                  seen_q, seen_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_rst_q;

  logic        fire;
  logic        arm;
  logic        word_valid;
  logic [31:0] word;
  logic [31:0] len;

  assign in_ready = (state_q == LD_LEN) || (state_q == LD_DATA);
  assign busy     = in_ready;
  assign done     = (state_q == LD_DONE);
  assign err      = (state_q == LD_ERR);
  assign fire     = in_valid && in_ready;
  assign arm      = start && !busy;
  assign len      = le_word(word);

  inst_loader_byte_packer u_packer (
    .CLK          (CLK),
    .RST          (RST),
    .clear_i      (arm),
    .byte_valid_i (fire),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    idle_d      = idle_q;
    seen_d      = seen_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      LD_IDLE, LD_DONE, LD_ERR: begin
        if (start) begin
          state_d = LD_LEN;
          idx_d   = '0;
          n_d     = '0;
          idle_d  = '0;
          seen_d  = 1'b0;
        end
      end
      LD_LEN, LD_DATA: begin
        if (fire) begin
          seen_d = 1'b1;
          idle_d = '0;
          if (word_valid) begin
            if (state_q == LD_LEN) begin
              n_d = len;
              if (len == 32'd0)           state_d = LD_DONE;
              else if (len > MEM_LIMIT)   state_d = LD_ERR;
              else begin
                state_d = LD_DATA;
                idx_d   = '0;
              end
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = ADDR_WIDTH'({idx_q[29:0], 2'b00});
              mem_wdata_d = word;
              idx_d       = idx_q + 32'd1;
              if (idx_q + 32'd1 == n_q) state_d = LD_DONE;
            end
          end
        end else if (seen_q && (TIMEOUT != 0)) begin
          if (idle_q == TO_LAST) state_d = LD_ERR;
          else                   idle_d  = idle_q + 32'd1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= LD_IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      idle_q      <= '0;
      seen_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= ZERO_WORD;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      idle_q      <= idle_d;
      seen_q      <= seen_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // Lags DONE by one cycle so the final write lands before the first fetch.
      cpu_rst_q   <= (state_q != LD_DONE);
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time writer for the instruction memory. It receives a byte stream (typically from the UART receiver), assembles 32-bit words, and writes them into the instruction RAM in the storage byte order that the instruction fetch path expects. The fetch path byte-swaps on read, so each fetched instruction comes out as the little-endian RISC-V encoding. The loader holds the CPU in reset until a complete image has been written.

## Interface
Parameters:
- MEM_WORDS, default `InstMemNum`: capacity of the instruction memory, in words.
- TIMEOUT, default 65535: maximum idle cycles allowed between accepted bytes while loading. 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle pulse; arms the loader from IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the loader accepts a byte on this cycle.
- mem_we  out  1  write strobe to the instruction RAM.
- mem_addr  out  `ADDR_WIDTH`  byte address of the write; bits [1:0] are always 0.
- mem_wdata  out  `DATA_WIDTH`  word in storage order.
- busy  out  1  the loader is in LEN or DATA.
- done  out  1  the image is complete.
- err  out  1  the load was aborted.
- cpu_rst  out  1  reset request to the CPU core.

## Operation
- Handshake: a byte transfers on a rising edge where in_valid && in_ready.
- in_ready is 1 only in states LEN and DATA.
- Stream format:
  - 4 bytes of word count N, little-endian.
  - Then N×4 data bytes.
- Word assembly: bytes b0..b3 in arrival order become mem_wdata = {b0,b1,b2,b3}. The fetch path swaps these back to {b3,b2,b1,b0}.
- States:
  - IDLE: wait for start.
  - LEN: collect the 4 count bytes. After the 4th byte:
    - N==0 → DONE.
    - N>MEM_WORDS → ERR.
    - otherwise → DATA, with word index 0.
  - DATA: on every 4th byte, issue one write at mem_addr = index<<2, then increment the index. When index reaches N → DONE.
  - DONE / ERR: hold until start (→ LEN) or RST.
- start while busy is ignored.
- On entry to LEN, the byte counter, word index and timeout counter are all cleared.
- Timeout: in LEN or DATA, once at least one byte of the load has been accepted, TIMEOUT consecutive cycles with no transfer → ERR. A partially assembled word is discarded and not written.
- cpu_rst is 1 in every state except DONE.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready, mem_we, busy, done, err = 0.
  - mem_addr, mem_wdata = 0.
  - cpu_rst = 1.
- All outputs are registered; in_ready, busy, done and err are decoded from the state register.
- Write latency: when the 4th byte of a word is accepted at edge k, mem_we=1 for exactly the cycle after edge k, with mem_addr and mem_wdata stable during that cycle.
- Throughput: back-to-back bytes are accepted every cycle. in_ready never drops between words.
- Last word: the state becomes DONE at the same edge k, so done rises in the same cycle as the final mem_we. cpu_rst falls one cycle later, at edge k+1, so the write commits before the first fetch.
- Counter widths: byte counter 2 bits, wraps 3→0. Word index and N are 32 bits, compared unsigned.
- RST asserted mid-load: the loader returns to IDLE immediately. Memory already written is not cleared.

## Structure
- config.vh provides `ADDR_WIDTH`, `DATA_WIDTH`, `InstMemNum`, `InstMemNumLog2` and `ZeroWord`.
- The state encodings `LdIdle`, `LdLen`, `LdData`, `LdDone` and `LdErr` (3 bits) are added to config.vh.
- Sub-module byte_packer: a 2-bit byte counter plus a 32-bit shift register. It emits word_valid together with word_data in {b0,b1,b2,b3} order. It is shared by the LEN and DATA states; LEN reinterprets its word as the little-endian count.

## Test plan
- Reset check: RST=1, then release → cpu_rst=1, in_ready=0, done=0, err=0. Bytes presented with no start pulse are not accepted.
- Two-word image: start, then bytes 02 00 00 00 13 05 10 00 93 05 20 00 at one per cycle →
  - write addr 0x0, wdata 0x13051000;
  - write addr 0x4, wdata 0x93052000;
  - done=1 with the second write; cpu_rst=0 one cycle later;
  - the fetch path reads 0x00100513 at address 0.
- Empty image: count bytes 00 00 00 00 → no mem_we; DONE is reached directly after the 4th byte.
- Oversize count: N = MEM_WORDS+1 → ERR, no writes, in_ready=0, cpu_rst stays 1. A following start restarts in LEN.
- Timeout: with TIMEOUT=16, send the count 01 00 00 00 and 2 data bytes, then stall 16 cycles → err=1 and no write occurs.
- Gaps and mid-load reset: random in_valid gaps shorter than TIMEOUT → the written data and addresses are identical to the gap-free run. RST asserted after the first write → IDLE immediately and cpu_rst=1.
